// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ARB,
    FETCH,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    WAIT_IDLE,
    GAP
  } t_arb_state;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bus: per-requester valid/data/last in, ready/grant back.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             grant;

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, grant
  );

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, grant
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester after rr_ptr, wrapping.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any_valid,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  assign any_valid = |req_valid;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_valid[cand_idx]) begin
        found             = 1'b1;
        pick_oh[cand_idx] = 1'b1;
        pick_idx          = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_Tx serializer between NUM_REQ byte-stream requesters,
// granting whole packets round-robin and sequencing the data_en/tx_en/tx_done handshake.
//
// state      | meaning
// ARB        | no owner; pick next requester round-robin
// FETCH      | owner granted; waiting for its next byte (stall timer running)
// ISSUE      | data_en pulse to UART_Tx with the captured byte
// WAIT_START | waiting for UART_Tx to raise tx_en
// WAIT_DONE  | waiting for UART_Tx tx_done
// WAIT_IDLE  | waiting for tx_en and tx_done both low before the next byte
// GAP        | post-packet idle clocks before re-arbitration
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CLKS   = 0,
  parameter int STALL_CLKS = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_arbiter_if.slave       req_bus,
  output logic                   uart_data_en,
  output logic [UART_DATA_W-1:0] uart_data,
  input  logic                   uart_tx_en,
  input  logic                   uart_tx_done,
  output logic                   busy,
  output logic                   err_stall
);

  localparam int                 IDX_W      = $clog2(NUM_REQ);
  localparam int                 STALL_W    = $clog2(STALL_CLKS);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CLKS - 1);
  localparam logic [7:0]         GAP_LAST   = 8'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  t_arb_state             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   data_en_d, busy_d, err_d;
  logic                   last_q, last_d;
  logic [STALL_W-1:0]     stall_q, stall_d;
  logic [7:0]             gap_q, gap_d;

  logic                   any_valid;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   sel_valid, sel_last;
  logic [UART_DATA_W-1:0] sel_data;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .pick_oh   (pick_oh),
    .pick_idx  (pick_idx)
  );

  // rr_ptr always holds the current owner's index while a grant is live
  assign sel_valid = req_bus.req_valid[rr_ptr_q];
  assign sel_last  = req_bus.req_last[rr_ptr_q];
  assign sel_data  = req_bus.req_data[int'(rr_ptr_q)*UART_DATA_W +: UART_DATA_W];

  assign req_bus.req_ready = (state_q == FETCH) ? grant_q : '0;
  assign req_bus.grant     = grant_q;
  assign uart_data         = data_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    last_d   = last_q;
    stall_d  = stall_q;
    gap_d    = gap_q;
    err_d    = 1'b0;
    case (state_q)
      ARB: begin
        if (any_valid) begin
          grant_d  = pick_oh;
          rr_ptr_d = pick_idx;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          stall_d = '0;
          state_d = ISSUE;
        end else if (stall_q == STALL_LAST) begin
          err_d   = 1'b1;
          grant_d = '0;
          stall_d = '0;
          state_d = ARB;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      ISSUE:      state_d = WAIT_START;
      WAIT_START: if (uart_tx_en) state_d = WAIT_DONE;
      WAIT_DONE:  if (uart_tx_done) state_d = WAIT_IDLE;
      WAIT_IDLE: begin
        // both low means the serializer is back in its idle state
        if (!uart_tx_done && !uart_tx_en) begin
          if (!last_q) begin
            state_d = FETCH;
          end else begin
            grant_d = '0;
            state_d = (GAP_CLKS == 0) ? ARB : GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ARB;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ARB;
    endcase
    data_en_d = (state_d == ISSUE);
    busy_d    = (state_d != ARB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      grant_q      <= '0;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      data_q       <= '0;
      last_q       <= 1'b0;
      stall_q      <= '0;
      gap_q        <= '0;
      uart_data_en <= 1'b0;
      busy         <= 1'b0;
      err_stall    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      stall_q      <= stall_d;
      gap_q        <= gap_d;
      uart_data_en <= data_en_d;
      busy         <= busy_d;
      err_stall    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: queued byte sources, a UART_Tx handshake model
// and a packet-level reference for grant order, byte order, gap length and stall release.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int GAP   = 5;
  localparam int STALL = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) req_bus ();

  logic       uart_data_en;
  logic [7:0] uart_data;
  logic       uart_tx_en;
  logic       uart_tx_done;
  logic       busy;
  logic       err_stall;

  uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CLKS(GAP), .STALL_CLKS(STALL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_bus      (req_bus),
    .uart_data_en (uart_data_en),
    .uart_data    (uart_data),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .err_stall    (err_stall)
  );

  int total = 0;
  int bad   = 0;

  // per requester byte source: {pause_after, last, data}
  logic [9:0] src_mem [NR][256];
  int         src_rd [NR];
  int         src_wr [NR];
  int         pause  [NR];
  bit         rand_pause;

  logic [7:0]    exp_q[$];
  int            grant_log[$];
  int            last_winner;
  logic [NR-1:0] prev_valid, prev_grant;
  logic          prev_busy;
  int            u_phase, u_cnt;
  bit            u_long;
  bit            last_xfer_last;
  int            gap_run, stall_run, pend;
  int            n_data_en, n_err, stall_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    int idx;
    for (int d = 1; d <= NR; d++) begin
      idx = (last + d) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic int log_at(input int k);
    if (k < grant_log.size()) return grant_log[k];
    return -1;
  endfunction

  function automatic int outstanding();
    int s = 0;
    for (int i = 0; i < NR; i++) s += src_wr[i] - src_rd[i];
    return s;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input bit last, input bit pz);
    src_mem[r][src_wr[r]] = {pz, last, d};
    src_wr[r]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
      pause[i]  = 0;
    end
  endtask

  task automatic reset_model();
    clear_src();
    exp_q.delete();
    last_winner    = NR - 1;
    prev_valid     = '0;
    prev_grant     = '0;
    prev_busy      = 1'b0;
    u_phase        = 0;
    u_cnt          = 0;
    last_xfer_last = 1'b0;
    gap_run        = 0;
    stall_run      = 0;
    pend           = -1;
    req_bus.req_valid = '0;
    req_bus.req_data  = '0;
    req_bus.req_last  = '0;
    uart_tx_en        = 1'b0;
    uart_tx_done      = 1'b0;
  endtask

  task automatic drive_reqs();
    logic [NR-1:0]   v, l;
    logic [NR*8-1:0] d;
    logic [9:0]      e;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        e = src_mem[i][src_rd[i]];
        d[i*8 +: 8] = e[7:0];
        l[i] = e[8];
        if (pause[i] > 0) pause[i]--;
        else v[i] = 1'b1;
      end else begin
        pause[i] = 0;
      end
    end
    req_bus.req_valid = v;
    req_bus.req_data  = d;
    req_bus.req_last  = l;
  endtask

  // One clock: retire last transfer, check outputs, advance UART model, drive sources.
  task automatic step();
    logic [9:0]    e;
    logic [NR-1:0] g, exp_g, xfer;
    bit            exp_err;
    int            w;
    @(negedge clk);
    if (pend >= 0) begin
      e = src_mem[pend][src_rd[pend]];
      src_rd[pend]++;
      exp_q.push_back(e[7:0]);
      last_xfer_last = e[8];
      if (e[9]) pause[pend] = rand_pause ? $urandom_range(1, 30) : 40;
      pend = -1;
    end

    g = req_bus.grant;
    exp_err = (prev_grant != 0) && (g == 0) && (stall_run >= STALL);
    chk("err_stall", err_stall, exp_err);
    if (err_stall) begin
      n_err++;
      stall_seen = stall_run;
    end
    if (stall_run >= STALL) chk("stall_release", g, 0);
    chk("grant_onehot", $onehot0(g), 1);
    chk("ready_in_grant", req_bus.req_ready & ~g, 0);
    if (prev_grant == 0) begin
      exp_g = '0;
      if (!prev_busy) begin
        w = rr_pick(prev_valid, last_winner);
        if (w >= 0) begin
          exp_g = NR'(1) << w;
          last_winner = w;
        end
      end
      chk("grant_pick", g, exp_g);
      if (g != 0) grant_log.push_back(oh_idx(g));
    end else if (g != 0) begin
      chk("grant_hold", g, prev_grant);
    end else if (!err_stall) begin
      chk("release_on_last", last_xfer_last, 1);
    end
    if (g != 0) chk("busy_owned", busy, 1);

    if (busy && g == 0) gap_run++;
    else begin
      if (gap_run > 0) chk("gap_len", gap_run, GAP);
      gap_run = 0;
    end

    if (uart_data_en) begin
      n_data_en++;
      chk("issue_uart_idle", u_phase, 0);
      chk("issue_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("uart_data", uart_data, exp_q.pop_front());
      u_phase = 1;
      u_cnt   = $urandom_range(0, 2);
    end else begin
      case (u_phase)
        1: if (u_cnt == 0) begin
             u_phase = 2;
             u_cnt   = u_long ? 6 : $urandom_range(1, 5);
           end else u_cnt--;
        2: if (u_cnt == 0) begin
             u_phase = 3;
             u_cnt   = $urandom_range(0, 1);
           end else u_cnt--;
        3: if (u_cnt == 0) u_phase = 0;
           else u_cnt--;
        default: u_phase = 0;
      endcase
    end
    uart_tx_en   = (u_phase == 2);
    uart_tx_done = (u_phase == 3);

    drive_reqs();
    prev_valid = req_bus.req_valid;
    prev_grant = g;
    prev_busy  = busy;
    #1;
    xfer = req_bus.req_ready & req_bus.req_valid;
    if (xfer != 0) begin
      pend      = oh_idx(xfer);
      stall_run = 0;
    end else if (req_bus.req_ready != 0) stall_run++;
    else stall_run = 0;
  endtask

  task automatic drain(input int max, input string tag);
    for (int n = 0; n < max; n++) begin
      step();
      if (outstanding() == 0 && !busy && req_bus.grant == 0 && u_phase == 0 &&
          pend < 0 && !uart_data_en) break;
    end
    chk({tag, "_drained"}, outstanding() + int'(busy), 0);
    chk({tag, "_no_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    u_long     = 1'b0;
    rand_pause = 1'b0;
    n_data_en  = 0;
    n_err      = 0;
    stall_seen = 0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_grant", req_bus.grant, 0);
    chk("rst_ready", req_bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_en", uart_data_en, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_err", err_stall, 0);
    rst_n = 1'b1;

    // single requester, three-byte packet
    grant_log.delete();
    n_data_en = 0;
    push_byte(0, 8'h55, 1'b0, 1'b0);
    push_byte(0, 8'hA3, 1'b0, 1'b0);
    push_byte(0, 8'h0F, 1'b1, 1'b0);
    drain(400, "p1");
    chk("p1_issues", n_data_en, 3);
    chk("p1_owners", grant_log.size(), 1);
    chk("p1_owner", log_at(0), 0);

    // requesters 1 and 2 together, twice
    clear_src();
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      push_byte(1, 8'h10 + 8'(r), 1'b0, 1'b0);
      push_byte(1, 8'h11 + 8'(r), 1'b1, 1'b0);
      push_byte(2, 8'h20 + 8'(r), 1'b0, 1'b0);
      push_byte(2, 8'h21 + 8'(r), 1'b1, 1'b0);
      drain(600, "p2");
    end
    chk("p2_owners", grant_log.size(), 4);
    chk("p2_seq0", log_at(0), 1);
    chk("p2_seq1", log_at(1), 2);
    chk("p2_seq2", log_at(2), 1);
    chk("p2_seq3", log_at(3), 2);

    // requesters 0 and 3 streaming one-byte packets; last owner was 2
    clear_src();
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      push_byte(0, 8'($urandom), 1'b1, 1'b0);
      push_byte(3, 8'($urandom), 1'b1, 1'b0);
    end
    drain(1500, "p3");
    chk("p3_owners", grant_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("p3_alternate", log_at(k), (k % 2 == 0) ? 3 : 0);

    // owner 1 goes quiet mid-packet while 2 waits
    clear_src();
    grant_log.delete();
    n_err = 0;
    push_byte(1, 8'hC1, 1'b0, 1'b1);
    push_byte(1, 8'hC2, 1'b0, 1'b0);
    push_byte(1, 8'hC3, 1'b1, 1'b0);
    push_byte(2, 8'hD1, 1'b1, 1'b0);
    drain(800, "p4");
    chk("p4_err_count", n_err, 1);
    chk("p4_stall_clks", stall_seen, STALL);
    chk("p4_seq0", log_at(0), 1);
    chk("p4_seq1", log_at(1), 2);
    chk("p4_seq2", log_at(2), 1);

    // randomized packets and pauses across all requesters
    rand_pause = 1'b1;
    for (int round = 0; round < 3; round++) begin
      clear_src();
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(0, 3) != 0) begin
          for (int p = 0; p < 3; p++) begin
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++)
              push_byte(r, 8'($urandom), b == n - 1, $urandom_range(0, 5) == 0);
          end
        end
      end
      drain(6000, "p5");
    end
    rand_pause = 1'b0;

    // asynchronous reset while waiting for tx_done
    clear_src();
    u_long = 1'b1;
    push_byte(0, 8'h99, 1'b0, 1'b0);
    push_byte(0, 8'h9A, 1'b1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      step();
      if (uart_tx_en) break;
    end
    @(posedge clk);
    #2;
    chk("p6_pre_busy", busy, 1);
    chk("p6_pre_grant", req_bus.grant, 1);
    rst_n = 1'b0;
    #1;
    chk("p6_rst_grant", req_bus.grant, 0);
    chk("p6_rst_data_en", uart_data_en, 0);
    chk("p6_rst_busy", busy, 0);
    chk("p6_rst_ready", req_bus.req_ready, 0);
    u_long = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    push_byte(0, 8'hE0, 1'b1, 1'b0);
    push_byte(3, 8'hE3, 1'b1, 1'b0);
    drain(600, "p6");
    chk("p6_seq0", log_at(0), 0);
    chk("p6_seq1", log_at(1), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
